// File: rtl/calc_serial_receiver_if.sv
// Serial result link between the calculator transmitter and its receiver.
// Latency: none (wires only).
// Backpressure: none; the receiver must keep up with every ClkTx rise.
interface calc_serial_receiver_if #(
    parameter int FRAME_W = 32
);
    logic               ClkTx;
    logic               DOutValid;
    logic               DataOut;
    logic [FRAME_W-1:0] RxData;
    logic               RxValid;
    logic               RxError;
    logic               RxBusy;
    logic [7:0]         FrameCount;

    modport master (
        output ClkTx, DOutValid, DataOut,
        input  RxData, RxValid, RxError, RxBusy, FrameCount
    );

    modport slave (
        input  ClkTx, DOutValid, DataOut,
        output RxData, RxValid, RxError, RxBusy, FrameCount
    );
endinterface

// File: rtl/calc_serial_receiver.sv
// Deserializes the MSB-first DataOut stream into FRAME_W-bit words, flagging truncated/overrun frames.
// Latency: RxValid/RxError pulse one Clk after the edge that captures the deciding bit.
// Backpressure: none; every ClkTx rise inside the DOutValid envelope is consumed.
module calc_serial_receiver #(
    parameter int FRAME_W = 32,
    parameter int CNT_W   = 6
) (
    input  logic                    Clk,
    input  logic                    Reset,
    calc_serial_receiver_if.slave   rx
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        WAITLOW = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               clktx_q;
    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-1:0] shift_q;

    logic               sample;
    logic               last_bit;
    logic               done;
    logic               trunc;
    logic               extra;
    logic [FRAME_W-1:0] word_nxt;

    assign sample = rx.ClkTx & ~clktx_q & rx.DOutValid;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sample) begin
                    state_nxt = last_bit ? WAITLOW : RECV;
                end
            end
            RECV: begin
                if (sample && last_bit) begin
                    state_nxt = WAITLOW;
                end else if (!rx.DOutValid) begin
                    state_nxt = IDLE;
                end
            end
            WAITLOW: begin
                if (!rx.DOutValid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // In IDLE the first bit is the whole word when FRAME_W is 1, so it completes at once.
    always_comb begin
        last_bit  = (state == IDLE) ? (FRAME_W == 1) : (cnt == CNT_W'(FRAME_W - 1));
        done      = sample && (state != WAITLOW) && last_bit;
        trunc     = (state == RECV) && !rx.DOutValid;
        extra     = (state == WAITLOW) && sample;
        word_nxt  = (state == IDLE) ? FRAME_W'(rx.DataOut)
                                    : ((shift_q << 1) | FRAME_W'(rx.DataOut));
        rx.RxBusy = (state == RECV);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            clktx_q       <= 1'b0;
            cnt           <= '0;
            shift_q       <= '0;
            rx.RxData     <= '0;
            rx.RxValid    <= 1'b0;
            rx.RxError    <= 1'b0;
            rx.FrameCount <= 8'd0;
        end else begin
            clktx_q    <= rx.ClkTx;
            rx.RxValid <= done;
            rx.RxError <= trunc | extra;
            if (sample && (state != WAITLOW)) begin
                shift_q <= word_nxt;
                cnt     <= (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
            end
            if (done) begin
                rx.RxData     <= word_nxt;
                rx.FrameCount <= rx.FrameCount + 8'd1;
                cnt           <= '0;
            end
            if (trunc) begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_calc_serial_receiver.sv
// Bench for calc_serial_receiver: directed frames with a queued scoreboard checked by a negedge monitor.
// Latency checked per event; backpressure n/a.
// Expected words, counts and due cycles are derived from the stimulus itself.
module tb_calc_serial_receiver;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    calc_serial_receiver_if #(.FRAME_W(32)) bus();

    calc_serial_receiver #(.FRAME_W(32), .CNT_W(6)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .rx    (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        logic [7:0]  cnt;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_data;
    logic [7:0]  m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called one negedge before the deciding edge, so the pulse is due at cyc+1.
    task automatic push_valid(input logic [31:0] word);
        m_cnt  = m_cnt + 8'd1;
        m_data = word;
        sb.push_back('{1'b0, word, m_cnt, cyc + 1});
    endtask

    task automatic push_err();
        sb.push_back('{1'b1, m_data, m_cnt, cyc + 1});
    endtask

    exp_t e;
    always @(negedge Clk) begin
        if (bus.RxValid === 1'b1 || bus.RxError === 1'b1) begin
            check("valid_error_exclusive", {31'b0, bus.RxValid & bus.RxError}, 32'd0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: RxValid=%b RxError=%b at cycle %0d, none expected",
                         bus.RxValid, bus.RxError, cyc);
            end else begin
                e = sb.pop_front();
                check("event_kind",  {31'b0, bus.RxError}, {31'b0, e.is_err});
                check("event_cycle", cyc, e.due);
                check("rx_data",     bus.RxData, e.data);
                check("frame_count", {24'b0, bus.FrameCount}, {24'b0, e.cnt});
            end
        end
    end

    task automatic do_reset(input int ncyc);
        @(negedge Clk);
        Reset         = 1'b1;
        bus.DOutValid = 1'b0;
        bus.ClkTx     = 1'b0;
        bus.DataOut   = 1'b0;
        repeat (ncyc) @(negedge Clk);
        Reset  = 1'b0;
        m_cnt  = 8'd0;
        m_data = 32'd0;
    endtask

    task automatic check_idle();
        check("idle_rxdata",  bus.RxData, 32'd0);
        check("idle_rxvalid", {31'b0, bus.RxValid}, 32'd0);
        check("idle_rxerror", {31'b0, bus.RxError}, 32'd0);
        check("idle_rxbusy",  {31'b0, bus.RxBusy}, 32'd0);
        check("idle_count",   {24'b0, bus.FrameCount}, 32'd0);
    endtask

    // ClkTx = Clk/4: two cycles low then two high per bit; DataOut held for the whole bit.
    task automatic send_frame(input logic [31:0] word, input int nbits, input bit rst_abort);
        for (int i = 0; i < nbits; i++) begin
            @(negedge Clk);
            bus.DOutValid = 1'b1;
            bus.ClkTx     = 1'b0;
            bus.DataOut   = (i < 32) ? word[31 - i] : 1'b1;
            @(negedge Clk);
            @(negedge Clk);
            bus.ClkTx = 1'b1;
            if (i == 31) push_valid(word);
            else if (i == 32) push_err();
            @(negedge Clk);
            check("rx_busy", {31'b0, bus.RxBusy}, (i < 31) ? 32'd1 : 32'd0);
        end
        if (rst_abort) begin
            do_reset(1);
        end else begin
            @(negedge Clk);
            bus.DOutValid = 1'b0;
            bus.ClkTx     = 1'b0;
            if (nbits < 32) push_err();
            @(negedge Clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ClkTx     = 1'b0;
        bus.DOutValid = 1'b0;
        bus.DataOut   = 1'b0;
        m_cnt         = 8'd0;
        m_data        = 32'd0;

        do_reset(2);
        check_idle();

        send_frame(32'hA5C3_0F81, 32, 1'b0);
        check("count_after_first", {24'b0, bus.FrameCount}, 32'd1);

        send_frame(32'hDEAD_BEEF, 17, 1'b0);
        check("data_kept_after_trunc", bus.RxData, 32'hA5C3_0F81);
        send_frame(32'h0000_0001, 32, 1'b0);

        send_frame(32'h1234_5678, 33, 1'b0);
        check("data_after_overrun",  bus.RxData, 32'h1234_5678);
        check("count_after_overrun", {24'b0, bus.FrameCount}, 32'd3);

        send_frame(32'h0F0F_0F0F, 10, 1'b1);
        check_idle();
        send_frame(32'hFFFF_FFFF, 32, 1'b0);
        check("data_after_reset_frame",  bus.RxData, 32'hFFFF_FFFF);
        check("count_after_reset_frame", {24'b0, bus.FrameCount}, 32'd1);

        do_reset(1);
        for (int f = 0; f < 256; f++) begin
            send_frame({f[7:0], ~f[7:0], f[7:0] ^ 8'h3C, 8'hC3}, 32, 1'b0);
        end
        check("count_wrapped", {24'b0, bus.FrameCount}, 32'd0);
        check("data_last_of_burst", bus.RxData, 32'hFF00_C3C3);

        repeat (4) @(negedge Clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
